vec_lsu_seq: RTL and testbench

- Sequential vector load/store unit. It executes one vector memory instruction element by element, consuming the LSU control bits produced by the vector controller: ld_inst, st_inst, stride_sel, index_str and index_unordered.
- It generates a valid/ready memory request stream and gathers load responses into a full-width destination vector.
- It sits between the vector decode/register-file stage and the data-memory port.
- For loads it returns the assembled vd value with a write-enable pulse.

---
 rtl/vec_lsu_seq_pkg.sv | 27 ++
 rtl/vec_lsu_addr_gen.sv | 72 +++++++
 rtl/vec_lsu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_vec_lsu_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_lsu_seq_pkg.sv
// Shared types for the sequential vector load/store unit: FSM states, element widths, addressing modes.
package vec_lsu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    EEW8  = 2'b00,
    EEW16 = 2'b01,
    EEW32 = 2'b10
  } eew_e;

  typedef enum logic [1:0] {
    UNIT    = 2'd0,
    STRIDED = 2'd1,
    INDEXED = 2'd2
  } lsu_mode_e;

  function automatic logic eew_legal(input logic [1:0] eew);
    return eew != 2'b11;
  endfunction

endpackage

// File: rtl/vec_lsu_addr_gen.sv
// Element address accumulator plus byte-enable and store-data lane replication.
module vec_lsu_addr_gen
  import vec_lsu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              load_i,
  input  logic              adv_i,
  input  lsu_mode_e         load_mode_i,
  input  eew_e              load_eew_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  eew_e              eew_i,
  input  logic [XLEN-1:0]   idx_i,
  input  logic [XLEN-1:0]   elem_i,
  output logic [XLEN-1:0]   addr_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   wdata_o
);

  localparam int BE_W = XLEN / 8;

  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] step_q;
  logic [XLEN-1:0] step_sel;

  // Indexed mode uses a zero step so the accumulator simply holds the base.
  always_comb begin
    step_sel = '0;
    case (load_mode_i)
      UNIT:    step_sel = XLEN'(1) << load_eew_i;
      STRIDED: step_sel = rs2_i;
      default: step_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc_q  <= '0;
      step_q <= '0;
    end else if (load_i) begin
      acc_q  <= rs1_i;
      step_q <= step_sel;
    end else if (adv_i) begin
      acc_q  <= acc_q + step_q;
    end
  end

  assign addr_o = acc_q + idx_i;

  always_comb begin
    be_o    = '1;
    wdata_o = elem_i;
    case (eew_i)
      EEW8: begin
        be_o    = BE_W'(1) << addr_o[1:0];
        wdata_o = {(XLEN/8){elem_i[7:0]}};
      end
      EEW16: begin
        be_o    = BE_W'(3) << {addr_o[1], 1'b0};
        wdata_o = {(XLEN/16){elem_i[15:0]}};
      end
      default: begin
        be_o    = '1;
        wdata_o = elem_i;
      end
    endcase
  end

endmodule

// File: rtl/vec_lsu_seq.sv
// Sequential vector LSU: one element per memory transaction, load results gathered into vd.
// Optional VEC_LSU_MISALIGN_CHK_EN adds misalign_err and suppresses misaligned requests.
module vec_lsu_seq
  import vec_lsu_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int VL_W = $clog2(VLEN/8) + 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic              ld_inst,
  input  logic              st_inst,
  input  logic              stride_sel,
  input  logic              index_str,
  input  logic              index_unordered,
  input  logic [1:0]        eew,
  input  logic [VL_W-1:0]   vl,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [VLEN-1:0]   vs2_data,
  input  logic [VLEN-1:0]   vs3_data,
  output logic              busy,
  output logic              done,
`ifdef VEC_LSU_MISALIGN_CHK_EN
  output logic              misalign_err,
`endif
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [VLEN-1:0]   vd_wdata,
  output logic              vd_wr_en
);

  localparam int OFF_W = VL_W + 5;

  lsu_state_e        state_q, state_d;
  logic [VL_W-1:0]   i_q, i_d, vl_q;
  logic              ld_q;
  eew_e              eew_q;
  lsu_mode_e         mode_q, mode_sel;
  logic [VLEN-1:0]   vs2_q, vd_q, vd_d;
  logic              accept, adv, last, req_valid, misaligned;
  logic [OFF_W-1:0]  off;
  logic [XLEN-1:0]   ew_mask, idx_off, st_elem, rd_elem, addr, wdata;
  logic [XLEN/8-1:0] be;

  assign accept = start && (state_q == IDLE) && (ld_inst ^ st_inst) && eew_legal(eew);
  // Unordered indexed accesses are executed in order, same as ordered ones.
  assign mode_sel = (index_str || (index_str && index_unordered)) ? INDEXED
                  : (stride_sel ? UNIT : STRIDED);

  assign off  = OFF_W'({i_q, 3'b000}) << eew_q;
  assign last = (i_q == vl_q - VL_W'(1));

  always_comb begin
    ew_mask = '1;
    rd_elem = mem_rdata;
    case (eew_q)
      EEW8: begin
        ew_mask = XLEN'(8'hFF);
        rd_elem = (mem_rdata >> {addr[1:0], 3'b000}) & XLEN'(8'hFF);
      end
      EEW16: begin
        ew_mask = XLEN'(16'hFFFF);
        rd_elem = (mem_rdata >> {addr[1], 4'b0000}) & XLEN'(16'hFFFF);
      end
      default: begin
        ew_mask = XLEN'(32'hFFFF_FFFF);
        rd_elem = mem_rdata & XLEN'(32'hFFFF_FFFF);
      end
    endcase
  end

  assign idx_off = (mode_q == INDEXED) ? (XLEN'(vs2_q >> off) & ew_mask) : '0;
  assign st_elem = XLEN'(vd_q >> off) & ew_mask;

`ifdef VEC_LSU_MISALIGN_CHK_EN
  logic err_q;

  always_comb begin
    misaligned = 1'b0;
    case (eew_q)
      EEW16:   misaligned = addr[0];
      EEW32:   misaligned = |addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                            err_q <= 1'b0;
    else if (accept)                         err_q <= 1'b0;
    else if (state_q == REQ && misaligned)   err_q <= 1'b1;
  end

  assign misalign_err = done && err_q;
  assign vd_wr_en     = done && ld_q && !err_q;
`else
  assign misaligned = 1'b0;
  assign vd_wr_en   = done && ld_q;
`endif

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    vd_d      = vd_q;
    adv       = 1'b0;
    req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          i_d     = '0;
          vd_d    = vs3_data;
          state_d = (vl == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (misaligned) begin
          state_d = DONE;
        end else begin
          req_valid = 1'b1;
          if (mem_req_ready) begin
            if (ld_q) begin
              state_d = WAIT_RSP;
            end else begin
              adv = 1'b1;
              if (last) state_d = DONE;
              else      i_d = i_q + VL_W'(1);
            end
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          vd_d = (vd_q & ~(VLEN'(ew_mask) << off)) | (VLEN'(rd_elem) << off);
          adv  = 1'b1;
          if (last) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + VL_W'(1);
            state_d = REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      vl_q    <= '0;
      ld_q    <= 1'b0;
      eew_q   <= EEW8;
      mode_q  <= UNIT;
      vs2_q   <= '0;
      vd_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      vd_q    <= vd_d;
      if (accept) begin
        vl_q   <= vl;
        ld_q   <= ld_inst;
        eew_q  <= eew_e'(eew);
        mode_q <= mode_sel;
        vs2_q  <= vs2_data;
      end
    end
  end

  vec_lsu_addr_gen #(.XLEN(XLEN)) u_addr_gen (
    .clk         (clk),
    .n_reset     (n_reset),
    .load_i      (accept),
    .adv_i       (adv),
    .load_mode_i (mode_sel),
    .load_eew_i  (eew_e'(eew)),
    .rs1_i       (rs1_data),
    .rs2_i       (rs2_data),
    .eew_i       (eew_q),
    .idx_i       (idx_off),
    .elem_i      (st_elem),
    .addr_o      (addr),
    .be_o        (be),
    .wdata_o     (wdata)
  );

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign mem_req_valid = req_valid;
  assign mem_we        = req_valid && !ld_q;
  assign mem_addr      = req_valid ? addr  : '0;
  assign mem_be        = req_valid ? be    : '0;
  assign mem_wdata     = req_valid ? wdata : '0;
  assign vd_wdata      = vd_q;

endmodule

// File: tb/tb_vec_lsu_seq.sv
// Directed self-checking bench for vec_lsu_seq (unit/strided/indexed, vl=0, illegal starts, reset abort).
module tb_vec_lsu_seq;

  localparam int XLEN = 32;
  localparam int VLEN = 512;
  localparam int VL_W = $clog2(VLEN/8) + 1;

  logic              clk = 1'b0;
  logic              n_reset;
  logic              start, ld_inst, st_inst, stride_sel, index_str, index_unordered;
  logic [1:0]        eew;
  logic [VL_W-1:0]   vl;
  logic [XLEN-1:0]   rs1_data, rs2_data;
  logic [VLEN-1:0]   vs2_data, vs3_data;
  logic              busy, done;
  logic              mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic [XLEN/8-1:0] mem_be;
  logic [VLEN-1:0]   vd_wdata;
  logic              vd_wr_en;
`ifdef VEC_LSU_MISALIGN_CHK_EN
  logic              misalign_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  vec_lsu_seq #(.XLEN(XLEN), .VLEN(VLEN), .VL_W(VL_W)) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .start           (start),
    .ld_inst         (ld_inst),
    .st_inst         (st_inst),
    .stride_sel      (stride_sel),
    .index_str       (index_str),
    .index_unordered (index_unordered),
    .eew             (eew),
    .vl              (vl),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .vs2_data        (vs2_data),
    .vs3_data        (vs3_data),
    .busy            (busy),
    .done            (done),
`ifdef VEC_LSU_MISALIGN_CHK_EN
    .misalign_err    (misalign_err),
`endif
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_be          (mem_be),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rdata       (mem_rdata),
    .vd_wdata        (vd_wdata),
    .vd_wr_en        (vd_wr_en)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic ss, input logic ix,
                       input logic [1:0] ew, input logic [VL_W-1:0] n,
                       input logic [XLEN-1:0] a1, input logic [XLEN-1:0] a2,
                       input logic [VLEN-1:0] v2, input logic [VLEN-1:0] v3);
    start = 1'b1; ld_inst = ld; st_inst = st; stride_sel = ss; index_str = ix;
    index_unordered = ix; eew = ew; vl = n;
    rs1_data = a1; rs2_data = a2; vs2_data = v2; vs3_data = v3;
    @(negedge clk);
    start = 1'b0; ld_inst = 1'b0; st_inst = 1'b0; stride_sel = 1'b0; index_str = 1'b0;
    index_unordered = 1'b0; eew = 2'b00; vl = '0;
    rs1_data = '0; rs2_data = '0; vs2_data = '0; vs3_data = '0;
  endtask

  // One element: wait (bounded) for the request, check it, accept it, and answer loads.
  task automatic serve(input string tag, input logic [XLEN-1:0] exp_addr, input logic [3:0] exp_be,
                       input logic is_ld, input logic [XLEN-1:0] data);
    int n = 0;
    while (!mem_req_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    expect_eq({tag, "_valid"}, VLEN'(mem_req_valid), VLEN'(1'b1));
    expect_eq({tag, "_addr"},  VLEN'(mem_addr), VLEN'(exp_addr));
    expect_eq({tag, "_be"},    VLEN'(mem_be), VLEN'(exp_be));
    expect_eq({tag, "_we"},    VLEN'(mem_we), VLEN'(!is_ld));
    if (!is_ld) expect_eq({tag, "_wdata"}, VLEN'(mem_wdata), VLEN'(data));
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    if (is_ld) begin
      expect_eq({tag, "_wait_novalid"}, VLEN'(mem_req_valid), VLEN'(1'b0));
      mem_rsp_valid = 1'b1;
      mem_rdata     = data;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
    end
  endtask

  task automatic check_done(input string tag, input logic exp_wr, input logic chk_vd,
                            input logic [VLEN-1:0] exp_vd);
    expect_eq({tag, "_done"},  VLEN'(done), VLEN'(1'b1));
    expect_eq({tag, "_busy"},  VLEN'(busy), VLEN'(1'b1));
    expect_eq({tag, "_vdwr"},  VLEN'(vd_wr_en), VLEN'(exp_wr));
    if (chk_vd) expect_eq({tag, "_vd"}, vd_wdata, exp_vd);
    @(negedge clk);
    expect_eq({tag, "_done_off"}, VLEN'(done), VLEN'(1'b0));
    expect_eq({tag, "_idle"},     VLEN'(busy), VLEN'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VLEN-1:0] v2, v3, exp;

    n_reset = 1'b0; start = 1'b0; ld_inst = 1'b0; st_inst = 1'b0; stride_sel = 1'b0;
    index_str = 1'b0; index_unordered = 1'b0; eew = 2'b00; vl = '0;
    rs1_data = '0; rs2_data = '0; vs2_data = '0; vs3_data = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    expect_eq("rst_busy",  VLEN'(busy), '0);
    expect_eq("rst_done",  VLEN'(done), '0);
    expect_eq("rst_valid", VLEN'(mem_req_valid), '0);
    expect_eq("rst_addr",  VLEN'(mem_addr), '0);
    expect_eq("rst_be",    VLEN'(mem_be), '0);
    expect_eq("rst_wdata", VLEN'(mem_wdata), '0);
    expect_eq("rst_we",    VLEN'(mem_we), '0);
    expect_eq("rst_vd",    vd_wdata, '0);
    expect_eq("rst_vdwr",  VLEN'(vd_wr_en), '0);
    n_reset = 1'b1;
    @(negedge clk);

    // Unit-stride 32-bit load of four elements
    v3 = {64{8'h5A}};
    issue(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, VL_W'(4), 32'h100, 32'h0, '0, v3);
    expect_eq("ul_busy", VLEN'(busy), VLEN'(1'b1));
    serve("ul0", 32'h100, 4'hF, 1'b1, 32'h0000_00A0);
    serve("ul1", 32'h104, 4'hF, 1'b1, 32'h0000_00A1);
    serve("ul2", 32'h108, 4'hF, 1'b1, 32'h0000_00A2);
    serve("ul3", 32'h10C, 4'hF, 1'b1, 32'h0000_00A3);
    exp = v3;
    exp[31:0] = 32'hA0; exp[63:32] = 32'hA1; exp[95:64] = 32'hA2; exp[127:96] = 32'hA3;
    check_done("ul", 1'b1, 1'b1, exp);

    // Constant-stride byte store
    v3 = '0;
    v3[23:0] = 24'h33_2211;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, VL_W'(3), 32'h200, 32'h5, '0, v3);
    serve("ss0", 32'h200, 4'h1, 1'b0, 32'h1111_1111);
    serve("ss1", 32'h205, 4'h2, 1'b0, 32'h2222_2222);
    serve("ss2", 32'h20A, 4'h4, 1'b0, 32'h3333_3333);
    check_done("ss", 1'b0, 1'b0, '0);

    // Indexed halfword load with back-pressure and a start while busy
    v2 = '0;
    v2[31:0] = 32'h0002_0006;
    v3 = {64{8'h77}};
    issue(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, VL_W'(2), 32'h300, 32'h0, v2, v3);
    for (int k = 0; k < 3; k++) begin
      expect_eq("ix_hold_valid", VLEN'(mem_req_valid), VLEN'(1'b1));
      expect_eq("ix_hold_addr",  VLEN'(mem_addr), VLEN'(32'h306));
      if (k == 0) begin
        start = 1'b1; st_inst = 1'b1; eew = 2'b10; vl = VL_W'(1); rs1_data = 32'h900;
      end
      @(negedge clk);
      start = 1'b0; st_inst = 1'b0; eew = 2'b00; vl = '0; rs1_data = '0;
    end
    serve("ix0", 32'h306, 4'hC, 1'b1, 32'hBEEF_0000);
    serve("ix1", 32'h302, 4'hC, 1'b1, 32'h1234_0000);
    exp = v3;
    exp[15:0] = 16'hBEEF; exp[31:16] = 16'h1234;
    check_done("ix", 1'b1, 1'b1, exp);

    // vl = 0 load completes without any request
    v3 = {16{32'hC0FF_EE00}};
    issue(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, VL_W'(0), 32'h400, 32'h0, '0, v3);
    expect_eq("vl0_novalid", VLEN'(mem_req_valid), '0);
    check_done("vl0", 1'b1, 1'b1, v3);

    // Illegal starts are ignored
    issue(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, VL_W'(2), 32'h600, 32'h0, '0, '0);
    expect_eq("ill_ldst_busy",  VLEN'(busy), '0);
    expect_eq("ill_ldst_valid", VLEN'(mem_req_valid), '0);
    @(negedge clk);
    expect_eq("ill_ldst_done",  VLEN'(done), '0);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, VL_W'(2), 32'h600, 32'h0, '0, '0);
    expect_eq("ill_eew_busy",   VLEN'(busy), '0);
    @(negedge clk);
    expect_eq("ill_eew_done",   VLEN'(done), '0);

`ifdef VEC_LSU_MISALIGN_CHK_EN
    // Misaligned word load is suppressed and flagged
    issue(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, VL_W'(2), 32'h102, 32'h0, '0, {64{8'h11}});
    expect_eq("mis_novalid", VLEN'(mem_req_valid), '0);
    @(negedge clk);
    expect_eq("mis_novalid2", VLEN'(mem_req_valid), '0);
    expect_eq("mis_err", VLEN'(misalign_err), VLEN'(1'b1));
    check_done("mis", 1'b0, 1'b0, '0);
    expect_eq("mis_err_off", VLEN'(misalign_err), '0);
`else
    // Misaligned halfword store is issued as-is
    v3 = '0;
    v3[15:0] = 16'hABCD;
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, VL_W'(1), 32'h203, 32'h0, '0, v3);
    serve("mis", 32'h203, 4'hC, 1'b0, 32'hABCD_ABCD);
    check_done("mis", 1'b0, 1'b0, '0);
`endif

    // Reset during WAIT_RSP aborts; a late response is ignored
    issue(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, VL_W'(2), 32'h500, 32'h0, '0, {64{8'h99}});
    expect_eq("ra_valid", VLEN'(mem_req_valid), VLEN'(1'b1));
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    expect_eq("ra_wait_busy", VLEN'(busy), VLEN'(1'b1));
    n_reset = 1'b0;
    #1;
    expect_eq("ra_busy",  VLEN'(busy), '0);
    expect_eq("ra_valid0", VLEN'(mem_req_valid), '0);
    expect_eq("ra_done",  VLEN'(done), '0);
    expect_eq("ra_vd",    vd_wdata, '0);
    expect_eq("ra_vdwr",  VLEN'(vd_wr_en), '0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hDEAD_BEEF;
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    expect_eq("ra_late_busy", VLEN'(busy), '0);
    expect_eq("ra_late_done", VLEN'(done), '0);
    expect_eq("ra_late_vd",   vd_wdata, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
